// File: rtl/obi_stall_responder.sv
`default_nettype none
// ============================================================================
// Module      : obi_stall_responder
// Description : OBI memory responder with programmable grant stall and
//               response latency; in-order response FIFO of DEPTH entries.
//               Optional error responses for out-of-range addresses when
//               OBI_STALL_RESPONDER_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_stall_responder #(
    parameter int MEM_AW = 10,
    parameter int DEPTH  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic [3:0]  gnt_stall_i,
    input  logic [3:0]  rsp_lat_i
`ifdef OBI_STALL_RESPONDER_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_WORDS = 1 << MEM_AW;
`ifdef OBI_STALL_RESPONDER_ERR_EN
    localparam int c_ENT_W = 33;
`else
    localparam int c_ENT_W = 32;
`endif
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

    logic [31:0]        mem_q  [c_WORDS];
    logic [c_ENT_W-1:0] fifo_q [DEPTH];

    logic [3:0]         stall_q, stall_d;
    logic [c_PTR_W-1:0] wptr_q, wptr_d;
    logic [c_PTR_W-1:0] rptr_q, rptr_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         age_q, age_d;
    logic [3:0]         lat_q, lat_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [MEM_AW-1:0]  w_idx;
    logic               w_addr_err;
    logic               w_push;
    logic               w_pop;
    logic               w_new_head;
    logic               w_unused;
    logic [31:0]        w_rsp_data;
    logic [c_ENT_W-1:0] w_push_ent;
    logic [c_ENT_W-1:0] w_head_nxt;

    assign w_idx    = addr_i[MEM_AW+1:2];
    assign w_unused = ^{addr_i[31:MEM_AW+2], addr_i[1:0]};

`ifdef OBI_STALL_RESPONDER_ERR_EN
    assign w_addr_err = |addr_i[31:MEM_AW+2];
`else
    assign w_addr_err = 1'b0;
`endif

    // Writes and errored transfers respond with zero data.
    assign w_rsp_data = (we_i || w_addr_err) ? 32'h0 : mem_q[w_idx];

`ifdef OBI_STALL_RESPONDER_ERR_EN
    assign w_push_ent = {w_addr_err, w_rsp_data};
`else
    assign w_push_ent = w_rsp_data;
`endif

    // No full bypass: a pop in the same cycle does not open the grant.
    assign gnt_o  = req_i && !rst_i && (stall_q == gnt_stall_i) && (cnt_q != c_FULL);
    assign w_push = req_i && gnt_o;
    assign w_pop  = rvalid_q;

    always_ff @(posedge clk_i) begin
        if (w_push && we_i && !w_addr_err) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_q[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fifo_q[wptr_q] <= w_push_ent;
        end
    end

    always_comb begin
        stall_d    = stall_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        age_d      = 4'd0;
        lat_d      = lat_q;
        w_new_head = 1'b0;
        w_head_nxt = '0;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;

        if (!req_i || w_push) begin
            stall_d = 4'd0;
        end else if (stall_q < gnt_stall_i) begin
            stall_d = stall_q + 4'd1;
        end else begin
            stall_d = gnt_stall_i;
        end

        if (w_push) begin
            wptr_d = (wptr_q == c_LAST) ? '0 : wptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rptr_d = (rptr_q == c_LAST) ? '0 : rptr_q + c_PTR_W'(1);
        end

        if (w_push && !w_pop) begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            cnt_d = cnt_q - c_CNT_W'(1);
        end

        // A fresh head restarts its age and captures the latency setting.
        w_new_head = (cnt_d != '0) && (w_pop || (cnt_q == '0));
        if (w_new_head) begin
            age_d = 4'd0;
            lat_d = rsp_lat_i;
        end else if (cnt_d != '0) begin
            age_d = (age_q == 4'hF) ? age_q : age_q + 4'd1;
        end

        // Response outputs are registered, so evaluate next cycle's head now.
        if ((cnt_q == '0) || (w_pop && (cnt_q == c_CNT_W'(1)))) begin
            w_head_nxt = w_push_ent;
        end else begin
            w_head_nxt = fifo_q[rptr_d];
        end

        rvalid_d = (cnt_d != '0) && (age_d == lat_d);
        if (rvalid_d) begin
            rdata_d = w_head_nxt[31:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q  <= 4'd0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            age_q    <= 4'd0;
            lat_q    <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            stall_q  <= stall_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            age_q    <= age_d;
            lat_q    <= lat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

`ifdef OBI_STALL_RESPONDER_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (rvalid_d) begin
            err_q <= w_head_nxt[32];
        end
    end

    assign err_o = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_obi_stall_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_stall_responder
// Description : Directed self-checking bench for obi_stall_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_stall_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [3:0]  gnt_stall_i;
    logic [3:0]  rsp_lat_i;
    logic        err_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

`ifdef OBI_STALL_RESPONDER_ERR_EN
    logic err_o;
    assign err_s = err_o;
`else
    assign err_s = 1'b0;
`endif

    obi_stall_responder #(
        .MEM_AW (10),
        .DEPTH  (2)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .gnt_stall_i (gnt_stall_i),
`ifdef OBI_STALL_RESPONDER_ERR_EN
        .err_o       (err_o),
`endif
        .rsp_lat_i   (rsp_lat_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns grant wait, response latency and data.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int gw, output int rw);
        req_i = 1'b1; we_i = wr; addr_i = a; be_i = be; wdata_i = wd;
        gw = 0;
        #4;
        while (!gnt_o && gw < 40) begin
            @(posedge clk_i); #5;
            gw++;
        end
        @(posedge clk_i); #1;
        req_i = 1'b0; we_i = 1'b0;
        rw = 1;
        #4;
        while (!rvalid_o && rw < 40) begin
            @(posedge clk_i); #5;
            rw++;
        end
        rd = rdata_o;
        er = err_s;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          gw, rw;

        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0;
        wdata_i = '0; gnt_stall_i = 4'd0; rsp_lat_i = 4'd0;
        repeat (2) @(posedge clk_i);
        #1;
        req_i = 1'b1;
        #4;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        @(posedge clk_i); #1;
        req_i = 1'b0; rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Back-to-back write then read of the same word
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; be_i = 4'hF; wdata_i = 32'hDEADBEEF;
        #4;
        chk("b2b_gnt0", gnt_o, 1);
        chk("b2b_rv0", rvalid_o, 0);
        @(posedge clk_i); #1;
        we_i = 1'b0;
        #4;
        chk("b2b_gnt1", gnt_o, 1);
        chk("b2b_rv1", rvalid_o, 1);
        chk("b2b_wrsp", rdata_o, 32'h0);
        @(posedge clk_i); #1;
        req_i = 1'b0;
        #4;
        chk("b2b_rv2", rvalid_o, 1);
        chk("b2b_rdata", rdata_o, 32'hDEADBEEF);
        @(posedge clk_i); #5;
        chk("b2b_rv3", rvalid_o, 0);
        chk("b2b_hold", rdata_o, 32'hDEADBEEF);
        @(posedge clk_i); #1;

        // Grant stall of 3 cycles
        gnt_stall_i = 4'd3;
        xfer(1'b0, 32'h10, 4'h0, 32'h0, rd, er, gw, rw);
        chk("stall_gw", gw, 3);
        chk("stall_rw", rw, 1);
        chk("stall_rd", rd, 32'hDEADBEEF);
        gnt_stall_i = 4'd1;
        xfer(1'b0, 32'h10, 4'h0, 32'h0, rd, er, gw, rw);
        chk("stall1_gw", gw, 1);
        gnt_stall_i = 4'd0;

        // FIFO full with long latency
        rsp_lat_i = 4'd5;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
        for (int c = 0; c < 20; c++) begin
            if (c == 8) req_i = 1'b0;
            #4;
            chk("full_gnt", gnt_o, (c == 0 || c == 1 || c == 7) ? 1 : 0);
            chk("full_rv", rvalid_o, (c == 6 || c == 12 || c == 18) ? 1 : 0);
            if (c == 6 || c == 12 || c == 18) chk("full_rdata", rdata_o, 32'hDEADBEEF);
            @(posedge clk_i); #1;
        end
        rsp_lat_i = 4'd0;

        // Byte enables and low-address-bit aliasing
        xfer(1'b1, 32'h0, 4'hF, 32'h0, rd, er, gw, rw);
        chk("be_clr_rw", rw, 1);
        chk("be_clr_rsp", rd, 32'h0);
        xfer(1'b1, 32'h0, 4'b0101, 32'h11223344, rd, er, gw, rw);
        xfer(1'b0, 32'h0, 4'h0, 32'h0, rd, er, gw, rw);
        chk("be_rd", rd, 32'h00220044);
        rsp_lat_i = 4'd2;
        xfer(1'b0, 32'h3, 4'h0, 32'h0, rd, er, gw, rw);
        chk("lat2_rw", rw, 3);
        chk("lat2_rd", rd, 32'h00220044);
        rsp_lat_i = 4'd5;

        // Reset with two writes outstanding
        req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h20; wdata_i = 32'hAAAA5555;
        #4;
        chk("rmid_gnt0", gnt_o, 1);
        @(posedge clk_i); #1;
        addr_i = 32'h24; wdata_i = 32'h12345678;
        #4;
        chk("rmid_gnt1", gnt_o, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1; we_i = 1'b0;
        #4;
        chk("rmid_gnt", gnt_o, 0);
        chk("rmid_rv", rvalid_o, 0);
        chk("rmid_rdata", rdata_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; req_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #4;
            chk("rmid_norv", rvalid_o, 0);
            @(posedge clk_i); #1;
        end
        rsp_lat_i = 4'd0;
        xfer(1'b0, 32'h20, 4'h0, 32'h0, rd, er, gw, rw);
        chk("rmid_mem20", rd, 32'hAAAA5555);
        xfer(1'b0, 32'h24, 4'h0, 32'h0, rd, er, gw, rw);
        chk("rmid_mem24", rd, 32'h12345678);
        xfer(1'b0, 32'h10, 4'h0, 32'h0, rd, er, gw, rw);
        chk("rmid_mem10", rd, 32'hDEADBEEF);

`ifdef OBI_STALL_RESPONDER_ERR_EN
        xfer(1'b0, 32'h80000000, 4'h0, 32'h0, rd, er, gw, rw);
        chk("err_rd_rw", rw, 1);
        chk("err_rd_err", er, 1);
        chk("err_rd_data", rd, 32'h0);
        xfer(1'b1, 32'h80000010, 4'hF, 32'hFFFFFFFF, rd, er, gw, rw);
        chk("err_wr_err", er, 1);
        xfer(1'b0, 32'h10, 4'h0, 32'h0, rd, er, gw, rw);
        chk("err_ok_err", er, 0);
        chk("err_mem", rd, 32'hDEADBEEF);
`else
        xfer(1'b0, 32'h00001010, 4'h0, 32'h0, rd, er, gw, rw);
        chk("alias_rd", rd, 32'hDEADBEEF);
        xfer(1'b1, 32'hFFFFF020, 4'hF, 32'hCAFEF00D, rd, er, gw, rw);
        xfer(1'b0, 32'h20, 4'h0, 32'h0, rd, er, gw, rw);
        chk("alias_wr", rd, 32'hCAFEF00D);
        chk("alias_err", er, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obi_stall_responder.md
OBI_STALL_RESPONDER -- requirements
Module: obi_stall_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the maximum number of outstanding responses (power of 2, at least 1).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_i, input, 1: initiator request.
REQ-006 SHALL have port addr_i, input, 32: byte address; word index = addr_i[MEM_AW+1:2].
REQ-007 SHALL have port we_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port be_i, input, 4: byte enables for writes.
REQ-009 SHALL have port wdata_i, input, 32: write data.
REQ-010 SHALL have port gnt_o, output, 1: grant; a transfer is accepted in any cycle where req_i and gnt_o are both 1.
REQ-011 SHALL have port rvalid_o, output, 1: response valid, one cycle per accepted transfer.
REQ-012 SHALL have port rdata_o, output, 32: read data, qualified by rvalid_o.
REQ-013 SHALL have port gnt_stall_i, input, 4: number of request cycles to withhold grant.
REQ-014 SHALL have port rsp_lat_i, input, 4: number of extra response latency cycles.

Function
REQ-015 SHALL drive gnt_o combinationally as req_i AND (stall counter == gnt_stall_i) AND (FIFO count < DEPTH).
- gnt_stall_i = 0 therefore grants in the same cycle as the request.
REQ-016 SHALL increment the 4-bit stall counter each cycle req_i=1 and the counter < gnt_stall_i; clear it on acceptance or whenever req_i=0.
- The counter saturates at gnt_stall_i; it never wraps.
REQ-017 SHALL perform writes in the accept cycle, updating only bytes with be_i[k]=1; the write response carries rdata_o = 0.
REQ-018 SHALL read the memory word in the accept cycle and push it to the response FIFO, so a read following a write to the same word returns the written data.
REQ-019 SHALL NOT grant while the FIFO holds DEPTH entries, even if a pop occurs in the same cycle (no full bypass).
REQ-020 SHALL support a push and a pop in the same cycle when not full; count is unchanged.
REQ-021 SHALL return responses strictly in acceptance order, at most one per cycle.
REQ-022 SHALL implement a head-age counter that restarts from 0 whenever a new entry becomes FIFO head; rvalid_o=1 in the cycle the head age reaches rsp_lat_i, provided the head has been present for at least one full cycle.
- Minimum latency: rvalid_o one cycle after accept (rsp_lat_i=0); L+1 cycles for rsp_lat_i=L with an empty FIFO.
REQ-023 SHALL register rvalid_o and rdata_o; rdata_o holds its last value while rvalid_o=0.
REQ-024 SHALL sample gnt_stall_i per cycle and rsp_lat_i when a new head forms; changing either mid-transfer affects only later comparisons.
REQ-025 SHALL alias addresses: bits above MEM_AW+1 and bits [1:0] are ignored (unless REQ-030 applies).

Reset
REQ-026 SHALL, while rst_i=1, force: gnt_o=0, rvalid_o=0, rdata_o=0, FIFO empty, stall and age counters 0.
REQ-027 SHALL discard outstanding responses on reset mid-operation; no rvalid_o SHALL appear for transfers accepted before reset.
REQ-028 SHALL leave memory contents unchanged by reset.

Configuration
REQ-029 SHALL compile an error-response feature in only when macro OBI_STALL_RESPONDER_ERR_EN is defined.
REQ-030 SHALL, with OBI_STALL_RESPONDER_ERR_EN defined, add output err_o (1 bit) with these rules:
- err_o is valid with rvalid_o and resets to 0.
- A transfer whose addr_i bits above MEM_AW+1 are non-zero returns err_o=1 and rdata_o=0.
- Such a write leaves memory unmodified.
REQ-031 SHALL, without the macro, have no err_o port and alias all addresses per REQ-025.

Verification
REQ-032 SHALL cover back-to-back grants: gnt_stall_i=0, rsp_lat_i=0, write 0xDEADBEEF to 0x10 then read 0x10 -> gnt_o in the same cycles as req_i; read rvalid_o two cycles after the first accept with rdata_o=0xDEADBEEF.
REQ-033 SHALL cover grant stall: gnt_stall_i=3 with req_i held -> gnt_o first high on the 4th request cycle; rvalid_o one cycle later.
REQ-034 SHALL cover FIFO full: DEPTH=2, rsp_lat_i=5, three consecutive reads -> first two granted, third gnt_o=0 until the cycle after the first rvalid_o.
REQ-035 SHALL cover byte enables: write 0x11223344 with be_i=0b0101 over 0x00000000, then read -> rdata_o=0x00220044.
REQ-036 SHALL cover reset mid-operation: assert rst_i with two responses outstanding -> rvalid_o stays 0 after reset release; memory retains prior writes.
REQ-037 SHALL cover error responses (macro defined): read addr 0x80000000 with MEM_AW=10 -> rvalid_o=1, err_o=1, rdata_o=0; memory unchanged.
